// File: rtl/br_commit_unit_pkg.sv
// Shared branch-tracking types and default sizing for the branch commit unit.
package br_commit_unit_pkg;

    localparam int SIM_BR_FETCH   = 2;
    localparam int SIM_BR_COMMIT  = 2;
    localparam int PRED_MAX_DEPTH = 8;
    localparam int BR_TAG_WIDTH   = $clog2(PRED_MAX_DEPTH);

    // One in-flight branch: allocated at fetch, resolved by execute.
    typedef struct packed {
        logic valid;
        logic resolved;
        logic pred;
        logic taken;
    } br_entry_t;

    function automatic logic entry_miss(input br_entry_t e);
        return e.pred ^ e.taken;
    endfunction

endpackage

// File: rtl/br_commit_unit_commit_sel.sv
// Head-window scan: picks the contiguous group of resolved entries that may
// retire this cycle, stopping after the first misprediction.
module br_commit_sel
    import br_commit_unit_pkg::*;
#(
    parameter int SIMBRCOM = SIM_BR_COMMIT,
    parameter int CNTW     = $clog2(SIMBRCOM + 1)
) (
    input  logic                     enable,
    input  br_entry_t [SIMBRCOM-1:0] window,
    output logic [SIMBRCOM-1:0]      commit,
    output logic [SIMBRCOM-1:0]      taken,
    output logic [SIMBRCOM-1:0]      miss,
    output logic                     group_miss,
    output logic [CNTW-1:0]          commit_cnt
);

    // Walk from the head; the first unready or mispredicted entry ends the group.
    always_comb begin
        logic run;
        commit     = '0;
        taken      = '0;
        miss       = '0;
        group_miss = 1'b0;
        commit_cnt = '0;
        run        = enable;
        for (int k = 0; k < SIMBRCOM; k++) begin
            if (run && window[k].valid && window[k].resolved) begin
                commit[k]  = 1'b1;
                taken[k]   = window[k].taken;
                miss[k]    = entry_miss(window[k]);
                commit_cnt = commit_cnt + CNTW'(1);
                if (miss[k]) begin
                    group_miss = 1'b1;
                    run        = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/br_commit_unit.sv
// In-order branch tracking buffer feeding predictor training: allocates at
// fetch, resolves out of order by tag, retires in program order.
module br_commit_unit
    import br_commit_unit_pkg::*;
#(
    parameter int SIMBRF   = SIM_BR_FETCH,
    parameter int SIMBRCOM = SIM_BR_COMMIT,
    parameter int DEPTH    = PRED_MAX_DEPTH,
    parameter int TAGW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     flush_,
    input  logic [SIMBRF-1:0]        br_,
    input  logic [SIMBRF-1:0]        pred_taken,
    output logic [SIMBRF*TAGW-1:0]   alloc_tag,
    output logic                     busy,
    input  logic                     exe_res_,
    input  logic [TAGW-1:0]          exe_tag,
    input  logic                     exe_taken_,
    output logic [SIMBRCOM-1:0]      br_commit_,
    output logic [SIMBRCOM-1:0]      br_taken_,
    output logic [SIMBRCOM-1:0]      br_pred_miss_,
    output logic                     flush_req_
);

    localparam int CNTW = $clog2(SIMBRCOM + 1);
    localparam int AW   = $clog2(SIMBRF + 1);
    localparam logic [TAGW:0] DEPTH_C = (TAGW+1)'(DEPTH);
    localparam logic [TAGW:0] FETCH_C = (TAGW+1)'(SIMBRF);

    br_entry_t [DEPTH-1:0]    entries;
    logic [TAGW-1:0]          head;
    logic [TAGW-1:0]          tail;
    logic [TAGW:0]            count;
    logic                     halt;
    logic [SIMBRF-1:0]        alloc_act;
    logic [AW-1:0]            alloc_cnt;
    br_entry_t [SIMBRCOM-1:0] window;
    logic [SIMBRCOM-1:0]      commit;
    logic [SIMBRCOM-1:0]      taken;
    logic [SIMBRCOM-1:0]      miss;
    logic                     group_miss;
    logic [CNTW-1:0]          commit_cnt;

    // busy looks only at the registered count; commits this cycle earn no credit.
    assign busy = (DEPTH_C - count) < FETCH_C;

    // Active slots take consecutive tags from tail; a busy buffer accepts nothing.
    always_comb begin
        logic [TAGW-1:0] offset;
        offset    = '0;
        alloc_tag = '0;
        alloc_act = busy ? '0 : ~br_;
        alloc_cnt = '0;
        for (int i = 0; i < SIMBRF; i++) begin
            alloc_tag[i*TAGW +: TAGW] = tail + offset;
            if (!br_[i]) begin
                offset = offset + TAGW'(1);
            end
            if (alloc_act[i]) begin
                alloc_cnt = alloc_cnt + AW'(1);
            end
        end
    end

    // Present the oldest SIMBRCOM entries, wrapping around the ring.
    always_comb begin
        window = '0;
        for (int k = 0; k < SIMBRCOM; k++) begin
            window[k] = entries[head + TAGW'(k)];
        end
    end

    br_commit_sel #(
        .SIMBRCOM (SIMBRCOM),
        .CNTW     (CNTW)
    ) u_commit_sel (
        .enable     (!halt),
        .window     (window),
        .commit     (commit),
        .taken      (taken),
        .miss       (miss),
        .group_miss (group_miss),
        .commit_cnt (commit_cnt)
    );

    // Entry storage: retire at head, resolve by tag, allocate at tail; flush wipes all.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            entries <= '0;
        end else if (!flush_) begin
            entries <= '0;
        end else begin
            for (int k = 0; k < SIMBRCOM; k++) begin
                if (commit[k]) begin
                    entries[head + TAGW'(k)].valid <= 1'b0;
                end
            end
            if (!exe_res_ && entries[exe_tag].valid && !entries[exe_tag].resolved) begin
                entries[exe_tag].resolved <= 1'b1;
                entries[exe_tag].taken    <= ~exe_taken_;
            end
            for (int i = 0; i < SIMBRF; i++) begin
                if (alloc_act[i]) begin
                    entries[alloc_tag[i*TAGW +: TAGW]] <= '{valid: 1'b1, resolved: 1'b0,
                                                           pred: pred_taken[i], taken: 1'b0};
                end
            end
        end
    end

    // Ring pointers, occupancy, post-mispredict hold and registered commit outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            halt          <= 1'b0;
            br_commit_    <= '1;
            br_taken_     <= '1;
            br_pred_miss_ <= '1;
            flush_req_    <= 1'b1;
        end else if (!flush_) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            halt          <= 1'b0;
            br_commit_    <= '1;
            br_taken_     <= '1;
            br_pred_miss_ <= '1;
            flush_req_    <= 1'b1;
        end else begin
            head          <= head + TAGW'(commit_cnt);
            tail          <= tail + TAGW'(alloc_cnt);
            count         <= count + (TAGW+1)'(alloc_cnt) - (TAGW+1)'(commit_cnt);
            halt          <= halt | group_miss;
            br_commit_    <= ~commit;
            br_taken_     <= ~taken;
            br_pred_miss_ <= ~miss;
            flush_req_    <= ~group_miss;
        end
    end

endmodule

// File: tb/tb_br_commit_unit.sv
// Directed bench for br_commit_unit (SIMBRF=2, SIMBRCOM=2, DEPTH=8).
module tb_br_commit_unit;

    logic       clk;
    logic       reset_;
    logic       flush_;
    logic [1:0] br_;
    logic [1:0] pred_taken;
    logic [5:0] alloc_tag;
    logic       busy;
    logic       exe_res_;
    logic [2:0] exe_tag;
    logic       exe_taken_;
    logic [1:0] br_commit_;
    logic [1:0] br_taken_;
    logic [1:0] br_pred_miss_;
    logic       flush_req_;

    int n_checks = 0;
    int n_fail   = 0;

    br_commit_unit #(
        .SIMBRF   (2),
        .SIMBRCOM (2),
        .DEPTH    (8)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .flush_        (flush_),
        .br_           (br_),
        .pred_taken    (pred_taken),
        .alloc_tag     (alloc_tag),
        .busy          (busy),
        .exe_res_      (exe_res_),
        .exe_tag       (exe_tag),
        .exe_taken_    (exe_taken_),
        .br_commit_    (br_commit_),
        .br_taken_     (br_taken_),
        .br_pred_miss_ (br_pred_miss_),
        .flush_req_    (flush_req_)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] br, input logic [1:0] pred,
                                  input logic res, input logic [2:0] tag, input logic tkn);
        br_        = br;
        pred_taken = pred;
        exe_res_   = res;
        exe_tag    = tag;
        exe_taken_ = tkn;
    endtask

    task automatic idle();
        apply_stimulus(2'b11, 2'b00, 1'b1, 3'd0, 1'b1);
    endtask

    task automatic do_flush();
        idle();
        flush_ = 1'b0;
        step();
        flush_ = 1'b1;
    endtask

    initial begin
        clk    = 1'b0;
        reset_ = 1'b0;
        flush_ = 1'b1;
        idle();
        step();
        step();
        check_output("rst_commit", 32'(br_commit_), 32'h3);
        check_output("rst_taken", 32'(br_taken_), 32'h3);
        check_output("rst_miss", 32'(br_pred_miss_), 32'h3);
        check_output("rst_flreq", 32'(flush_req_), 32'h1);
        check_output("rst_busy", 32'(busy), 32'h0);
        reset_ = 1'b1;
        step();

        $display("[TB] basic allocate and in-order commit");
        apply_stimulus(2'b00, 2'b01, 1'b1, 3'd0, 1'b1);
        #1;
        check_output("s1_tags", 32'(alloc_tag), 32'b001_000);
        step();
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd1, 1'b1);
        step();
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd0, 1'b0);
        step();
        idle();
        check_output("s1_wait", 32'(br_commit_), 32'h3);
        step();
        check_output("s1_commit", 32'(br_commit_), 32'h0);
        check_output("s1_taken", 32'(br_taken_), 32'h2);
        check_output("s1_miss", 32'(br_pred_miss_), 32'h3);
        check_output("s1_flreq", 32'(flush_req_), 32'h1);
        step();
        check_output("s1_after", 32'(br_commit_), 32'h3);
        check_output("s1_count", 32'(dut.count), 32'h0);

        $display("[TB] out-of-order resolve");
        do_flush();
        apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
        #1;
        check_output("s2_tags01", 32'(alloc_tag), 32'b001_000);
        step();
        #1;
        check_output("s2_tags23", 32'(alloc_tag), 32'b011_010);
        step();
        for (int t = 3; t >= 1; t--) begin
            apply_stimulus(2'b11, 2'b00, 1'b0, 3'(t), 1'b1);
            step();
            check_output("s2_hold", 32'(br_commit_), 32'h3);
        end
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd0, 1'b1);
        step();
        idle();
        check_output("s2_hold0", 32'(br_commit_), 32'h3);
        step();
        check_output("s2_c01", 32'(br_commit_), 32'h0);
        check_output("s2_c01_taken", 32'(br_taken_), 32'h3);
        step();
        check_output("s2_c23", 32'(br_commit_), 32'h0);
        check_output("s2_c23_miss", 32'(br_pred_miss_), 32'h3);
        step();
        check_output("s2_done", 32'(br_commit_), 32'h3);
        check_output("s2_count", 32'(dut.count), 32'h0);

        $display("[TB] mispredict terminates group");
        do_flush();
        apply_stimulus(2'b00, 2'b11, 1'b1, 3'd0, 1'b1);
        step();
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd1, 1'b0);
        step();
        check_output("s3_hold", 32'(br_commit_), 32'h3);
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd0, 1'b1);
        step();
        idle();
        step();
        check_output("s3_commit", 32'(br_commit_), 32'h2);
        check_output("s3_taken", 32'(br_taken_), 32'h3);
        check_output("s3_miss", 32'(br_pred_miss_), 32'h2);
        check_output("s3_flreq", 32'(flush_req_), 32'h0);
        step();
        check_output("s3_flreq_end", 32'(flush_req_), 32'h1);
        check_output("s3_halt1", 32'(br_commit_), 32'h3);
        step();
        check_output("s3_halt2", 32'(br_commit_), 32'h3);
        check_output("s3_count_pre", 32'(dut.count), 32'h1);
        do_flush();
        check_output("s3_count", 32'(dut.count), 32'h0);
        check_output("s3_busy", 32'(busy), 32'h0);
        apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
        #1;
        check_output("s3_tags", 32'(alloc_tag), 32'b001_000);
        idle();

        $display("[TB] full buffer and tag wrap");
        for (int n = 1; n <= 3; n++) begin
            apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
            step();
            check_output("s4_fill_busy", 32'(busy), 32'h0);
        end
        apply_stimulus(2'b10, 2'b00, 1'b1, 3'd0, 1'b1);
        step();
        check_output("s4_count7", 32'(dut.count), 32'h7);
        check_output("s4_busy7", 32'(busy), 32'h1);
        apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
        #1;
        check_output("s4_tag_full", 32'(alloc_tag), 32'b000_111);
        step();
        check_output("s4_ign_count", 32'(dut.count), 32'h7);
        check_output("s4_ign_tail", 32'(alloc_tag), 32'b000_111);
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd1, 1'b1);
        step();
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd0, 1'b1);
        step();
        idle();
        step();
        check_output("s4_commit", 32'(br_commit_), 32'h0);
        check_output("s4_count5", 32'(dut.count), 32'h5);
        check_output("s4_busy5", 32'(busy), 32'h0);
        apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
        #1;
        check_output("s4_wrap_pre", 32'(alloc_tag), 32'b000_111);
        step();
        check_output("s4_wrap_busy", 32'(busy), 32'h1);
        check_output("s4_wrap_tags", 32'(alloc_tag), 32'b010_001);
        idle();

        $display("[TB] flush beats allocate and resolve");
        do_flush();
        apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
        step();
        apply_stimulus(2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
        flush_ = 1'b0;
        step();
        flush_ = 1'b1;
        idle();
        check_output("s5_commit", 32'(br_commit_), 32'h3);
        check_output("s5_flreq", 32'(flush_req_), 32'h1);
        check_output("s5_count", 32'(dut.count), 32'h0);
        check_output("s5_busy", 32'(busy), 32'h0);
        step();
        check_output("s5_commit2", 32'(br_commit_), 32'h3);
        apply_stimulus(2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
        #1;
        check_output("s5_tags", 32'(alloc_tag), 32'b001_000);
        idle();

        $display("[TB] async reset mid-stream");
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(2'b00, 2'b11, 1'b1, 3'd0, 1'b1);
            step();
        end
        for (int t = 1; t <= 5; t++) begin
            apply_stimulus(2'b11, 2'b00, 1'b0, 3'(t), 1'b0);
            step();
        end
        check_output("s6_hold", 32'(br_commit_), 32'h3);
        apply_stimulus(2'b11, 2'b00, 1'b0, 3'd0, 1'b0);
        step();
        idle();
        step();
        check_output("s6_commit", 32'(br_commit_), 32'h0);
        check_output("s6_taken", 32'(br_taken_), 32'h0);
        check_output("s6_miss", 32'(br_pred_miss_), 32'h3);
        #2;
        reset_ = 1'b0;
        #1;
        check_output("s6_rst_commit", 32'(br_commit_), 32'h3);
        check_output("s6_rst_taken", 32'(br_taken_), 32'h3);
        check_output("s6_rst_flreq", 32'(flush_req_), 32'h1);
        check_output("s6_rst_count", 32'(dut.count), 32'h0);
        check_output("s6_rst_busy", 32'(busy), 32'h0);
        reset_ = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/br_commit_unit.md
Name: br_commit_unit

Overview:
- In-order branch tracking buffer that drives the training side of the branch predictor.
- At fetch, each predicted branch is allocated an entry tagged with its prediction.
- Execute resolves entries out of order by tag.
- Resolved entries retire in program order, up to SIMBRCOM per cycle, producing br_commit_/br_taken_/br_pred_miss_ in the same order the predictor's history FIFO was written. A committed misprediction raises a flush request.

Parameters:
- SIMBRF, `SimBrFetch, max branch allocations per cycle (same as predictor fetch width).
- SIMBRCOM, `SimBrCommit, max branch commits per cycle.
- DEPTH, `PredMaxDepth, entry count; power of two, >= SIMBRF.
- TAGW, $clog2(DEPTH), tag width (derived).

Ports:
- clk  in  1  clock
- reset_  in  1  async reset, active-low
- flush_  in  1  sync pipeline flush, active-low; clears all entries
- br_  in  SIMBRF  per-slot allocate request, active-low (same vector as predictor br_)
- pred_taken  in  SIMBRF  per-slot prediction from predictor
- alloc_tag  out  SIMBRF*TAGW  tag assigned to each slot, combinational
- busy  out  1  high when free entries < SIMBRF
- exe_res_  in  1  resolve strobe, active-low
- exe_tag  in  TAGW  tag being resolved
- exe_taken_  in  1  actual outcome, active-low = taken
- br_commit_  out  SIMBRCOM  commit valid per slot, active-low, registered
- br_taken_  out  SIMBRCOM  actual outcome per slot, active-low, registered
- br_pred_miss_  out  SIMBRCOM  misprediction per slot, active-low, registered
- flush_req_  out  1  mispredict flush request, active-low, registered

Behaviour:
- Reset: all entries invalid; head = tail = 0; count = 0. br_commit_, br_taken_, br_pred_miss_ all 1; flush_req_ = 1; busy = 0.
- Entry fields: valid, resolved, pred, taken. The buffer is circular; head and tail wrap modulo DEPTH.
- Allocation:
  - Active slots of br_ take consecutive tags starting at tail, in slot order; inactive slots are skipped.
  - alloc_tag[i] = tail + (number of active slots below i).
  - Entry written at the clock edge with valid=1, resolved=0, pred=pred_taken[i]. tail advances by the active count.
  - Allocation while busy=1 is ignored; upstream stalls on busy.
  - busy is computed from the registered count only; same-cycle commits are not credited.
- Resolve:
  - With exe_res_=0 and entry[exe_tag] valid and unresolved: set resolved=1, taken=~exe_taken_ at the edge.
  - Resolve of an invalid or already-resolved entry is ignored.
  - Resolve to an entry being allocated in the same cycle is illegal.
- Commit selection (combinational on registered state):
  - Scan k = 0..SIMBRCOM-1 from head. Slot k commits iff entries head..head+k are all valid and resolved, and no earlier slot in the group mispredicted.
  - miss = pred XOR taken.
  - The committing slots are a contiguous low-order group: slot 0 first, no holes.
  - A mispredicted entry commits and terminates the group.
- Commit outputs:
  - Registered one cycle after selection. Slot k drives br_commit_=0, br_taken_=~taken, br_pred_miss_=~miss.
  - Inactive slots drive 1.
  - Committed entries are invalidated; head advances by the committed count.
- Latency: a resolve in cycle N is visible in the buffer at N+1, with commit output at N+2 at the earliest.
- flush_req_ is driven low in the same cycle as the mispredicted commit's outputs, for exactly one cycle.
- After a mispredict commit, no further commits until flush_.
- flush_=0:
  - Priority over allocation, resolve and commit in that cycle. All entries are invalidated; head = tail = count = 0.
  - Registered outputs for that cycle return to inactive (1).
  - Any in-flight commit output already registered stays visible for its own cycle.
- Count: count_next = count + allocs − commits. Width TAGW+1; never exceeds DEPTH.
- Reset mid-operation: immediate return to reset state.

Decomposition:
- cpu_config.h gains BrTagWidth = $clog2(`PredMaxDepth).
- A shared br_entry packed typedef (valid, resolved, pred, taken) goes in the CPU package, for reuse by the branch unit.
- One sub-module, br_commit_sel: combinational head-window scan producing the commit vector, the miss-terminated group and the commit count.

Test Plan:
- SIMBRF=2, SIMBRCOM=2, DEPTH=8:
  - Allocate br_=2'b00 with pred=2'b01 → tags 0,1. Resolve tag1 not-taken, then tag0 taken. Two cycles after the tag0 resolve: br_commit_=2'b00, br_taken_=2'b10, br_pred_miss_=2'b11, flush_req_=1.
- Resolve out of order: tags 0..3 allocated, resolve order 3,2,1,0 → no commit until tag0 resolves, then slots 0-1, then 2-3 on consecutive cycles.
- Mispredict: tag0 pred taken, actual not-taken; tag1 resolved → only slot0 commits with br_pred_miss_[0]=0 and flush_req_=0 for one cycle. Tag1 is not committed; flush_ then empties the buffer, count=0, busy=0.
- Full: allocate 8 entries → busy=1 once count≥7. An allocation under busy is ignored (tail unchanged). Tags wrap 7→0 after commits.
- flush_ in the same cycle as an allocation and a resolve → buffer empty next cycle, no commit outputs.
- Async reset asserted mid-stream with 5 entries resolved → all outputs inactive immediately, count=0.
